// File: rtl/sim_ioctl_loader.sv
`default_nettype none
// ============================================================================
// sim_ioctl_loader : host byte stream to MiSTer-style ioctl download sequence
// Rev 1.0
// ============================================================================
module sim_ioctl_loader #(
  parameter int ADDR_W = 25,
  parameter int WR_GAP = 3,
  parameter int TAIL   = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        index_in,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;

  // One shared counter serves both the post-write gap and the tail window.
  localparam int CNT_MAX = (WR_GAP > TAIL) ? WR_GAP : TAIL;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ioctl_addr_q, ioctl_addr_d;
  logic [7:0]        ioctl_dout_q, ioctl_dout_d;
  logic [7:0]        ioctl_index_q, ioctl_index_d;

  // Abort suppresses the handshake so no source byte is consumed and lost.
  assign src_ready      = (state_q == S_FETCH) && !ioctl_wait && !abort;
  assign ioctl_download = (state_q == S_FETCH) || (state_q == S_WRITE) ||
                          (state_q == S_GAP)   || (state_q == S_TAIL);
  assign ioctl_wr       = (state_q == S_WRITE);
  assign ioctl_addr     = ioctl_addr_q;
  assign ioctl_dout     = ioctl_dout_q;
  assign ioctl_index    = ioctl_index_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign aborted        = (state_q == S_ABORT);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    addr_d        = addr_q;
    ioctl_addr_d  = ioctl_addr_q;
    ioctl_dout_d  = ioctl_dout_q;
    ioctl_index_d = ioctl_index_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ioctl_index_d = index_in;
          rem_d         = length;
          addr_d        = '0;
          ioctl_addr_d  = '0;
          cnt_d         = '0;
          state_d       = (length == '0) ? S_TAIL : S_FETCH;
        end
      end

      S_FETCH: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (src_valid && src_ready) begin
          ioctl_dout_d = src_data;
          ioctl_addr_d = addr_q;
          state_d      = S_WRITE;
        end
      end

      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - ADDR_W'(1);
        cnt_d  = '0;
        if (abort) begin
          state_d = S_ABORT;
        end else if (WR_GAP > 0) begin
          state_d = S_GAP;
        end else if (rem_q == ADDR_W'(1)) begin
          state_d = S_TAIL;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (rem_q == '0) ? S_TAIL : S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_TAIL: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (cnt_q == TAIL_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      addr_q        <= '0;
      ioctl_addr_q  <= '0;
      ioctl_dout_q  <= '0;
      ioctl_index_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      addr_q        <= addr_d;
      ioctl_addr_q  <= ioctl_addr_d;
      ioctl_dout_q  <= ioctl_dout_d;
      ioctl_index_q <= ioctl_index_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_ioctl_loader.sv
`default_nettype none
// Testbench for sim_ioctl_loader: expected writes and completions are queued when a
// download is issued; a monitor pops and compares them as the loader produces them.
module tb_sim_ioctl_loader;
  localparam int ADDR_W = 25;
  localparam int WR_GAP = 3;
  localparam int TAIL   = 2;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        index_in = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              abort = 1'b0;
  logic              src_valid = 1'b0;
  logic [7:0]        src_data = '0;
  logic              src_ready;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait = 1'b0;
  logic              busy;
  logic              done;
  logic              aborted;

  always #5 clk_sys = ~clk_sys;

  sim_ioctl_loader #(.ADDR_W(ADDR_W), .WR_GAP(WR_GAP), .TAIL(TAIL)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .index_in(index_in),
    .length(length), .abort(abort), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .busy(busy), .done(done), .aborted(aborted)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        idx;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  wr_t        exp_q[$];
  int         evt_q[$];   // 0 = done expected, 1 = aborted expected
  logic [7:0] src_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int start_cyc = 0, last_ev_cyc = 0, dl_cnt = 0, wr_in_dl = 0, wr_seen = 0;
  int valid_pct = 100;
  bit rand_wait = 1'b0;
  bit exact_gap = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source model: presents queued bytes in order with random gaps.
  initial begin : src_drv
    bit hs;
    forever begin
      @(negedge clk_sys);
      hs = src_valid && src_ready;
      @(posedge clk_sys); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        src_valid = 1'b1;
        src_data  = src_q[0];
      end else begin
        src_valid = 1'b0;
        src_data  = 8'($urandom);
      end
      if (rand_wait) ioctl_wait = ($urandom_range(99) < 25);
    end
  end

  // Monitor / scoreboard.
  initial begin : mon
    wr_t e;
    int  kind;
    forever begin
      @(negedge clk_sys);
      if (ioctl_download) dl_cnt++;
      if (ioctl_wr) begin
        wr_seen++;
        check("wr_in_download", ioctl_download, 1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr: got addr %0h data %0h, expected no write", ioctl_addr, ioctl_dout);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", ioctl_addr, e.addr);
          check("wr_data", ioctl_dout, e.data);
          check("wr_index", ioctl_index, e.idx);
        end
        if (wr_in_dl > 0) begin
          if (exact_gap) check("wr_period", cyc - last_ev_cyc, 2 + WR_GAP);
          else           check("wr_period_min", (cyc - last_ev_cyc) >= 2 + WR_GAP, 1);
        end
        wr_in_dl++;
        last_ev_cyc = cyc;
      end
      if (done || aborted) begin
        kind = done ? 0 : 1;
        check("single_completion", done && aborted, 0);
        if (evt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: got done=%0b aborted=%0b, expected none", done, aborted);
        end else begin
          check("completion_kind", kind, evt_q.pop_front());
        end
        if (done) begin
          check("done_pending_writes", exp_q.size(), 0);
          check("done_timing", cyc - last_ev_cyc, ((wr_in_dl > 0) ? WR_GAP : 0) + TAIL + 1);
          check("download_window", dl_cnt, cyc - start_cyc - 1);
        end
        check("end_download_low", ioctl_download, 0);
      end
    end
  end

  task automatic issue(input byte_q_t data, input logic [7:0] idx, input int pct);
    valid_pct = pct;
    for (int i = 0; i < data.size(); i++) begin
      src_q.push_back(data[i]);
      exp_q.push_back('{addr: ADDR_W'(i), data: data[i], idx: idx});
    end
    evt_q.push_back(0);
    @(posedge clk_sys); #1;
    start = 1'b1; index_in = idx; length = ADDR_W'(data.size());
    start_cyc = cyc; last_ev_cyc = cyc; dl_cnt = 0; wr_in_dl = 0;
    @(negedge clk_sys);
    check("start_download_low", ioctl_download, 0);
    @(posedge clk_sys); #1;
    start = 1'b0; index_in = 8'($urandom); length = ADDR_W'($urandom);
    check("start_latency", ioctl_download, 1);
    check("index_latched", ioctl_index, idx);
    check("busy_high", busy, 1);
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (evt_q.size() != 0 && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    if (evt_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL completion_timeout: got %0d pending completions, expected 0", evt_q.size());
      evt_q.delete(); exp_q.delete(); src_q.delete();
    end
    repeat (2) @(negedge clk_sys);
    check("idle_busy_low", busy, 0);
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_seen < target && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    if (wr_seen < target) begin
      checks++; errors++;
      $display("FAIL wr_timeout: got %0d writes, expected %0d", wr_seen, target);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_download"}, ioctl_download, 0);
    check({tag, "_wr"}, ioctl_wr, 0);
    check({tag, "_addr"}, ioctl_addr, 0);
    check({tag, "_dout"}, ioctl_dout, 0);
    check({tag, "_index"}, ioctl_index, 0);
    check({tag, "_flags"}, {busy, done, aborted, src_ready}, 0);
  endtask

  initial begin : stim
    byte_q_t d;
    int base;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    check_all_zero("reset");

    // Fixed four-byte download with exact pacing; a start mid-load must be ignored.
    exact_gap = 1'b1;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue(d, 8'h01, 100);
    repeat (3) @(posedge clk_sys);
    #1 start = 1'b1; index_in = 8'hAA; length = ADDR_W'(9);
    @(posedge clk_sys); #1 start = 1'b0;
    @(negedge clk_sys);
    check("busy_start_ignored_index", ioctl_index, 8'h01);
    wait_idle();
    exact_gap = 1'b0;
    check("hold_addr", ioctl_addr, 3);
    check("hold_dout", ioctl_dout, 8'h44);

    // Zero-length download.
    d = {};
    issue(d, 8'h02, 100);
    wait_idle();

    // Back-pressure after the second write.
    base = wr_seen;
    issue(rand_bytes(4), 8'h03, 100);
    wait_wr(base + 2);
    @(posedge clk_sys); #1 ioctl_wait = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      check("wait_no_ready", src_ready, 0);
      check("wait_no_wr", ioctl_wr, 0);
      @(posedge clk_sys); #1;
    end
    ioctl_wait = 1'b0;
    wait_idle();

    // Randomly gapped source, 16 bytes.
    issue(rand_bytes(16), 8'h04, 50);
    wait_idle();

    // Abort in the gap after byte 2 of 8, then restart.
    base = wr_seen;
    issue(rand_bytes(8), 8'h05, 100);
    wait_wr(base + 2);
    @(posedge clk_sys); #1;
    abort = 1'b1;
    exp_q.delete(); evt_q.delete(); evt_q.push_back(1); src_q.delete();
    @(posedge clk_sys); #1;
    abort = 1'b0;
    check("abort_download_low", ioctl_download, 0);
    check("abort_pulse", aborted, 1);
    wait_idle();
    issue(rand_bytes(3), 8'h06, 100);
    wait_idle();

    // Reset during a write strobe.
    issue(rand_bytes(6), 8'h07, 100);
    begin
      int n = 0;
      @(negedge clk_sys);
      while (!ioctl_wr && n < 200) begin
        @(negedge clk_sys);
        n++;
      end
      check("reset_found_write", ioctl_wr, 1);
    end
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    exp_q.delete(); evt_q.delete(); src_q.delete();
    @(negedge clk_sys);
    check_all_zero("midreset");

    // Random downloads with random back-pressure.
    rand_wait = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(rand_bytes($urandom_range(12, 1)), 8'($urandom), 60);
      wait_idle();
    end
    rand_wait = 1'b0;
    ioctl_wait = 1'b0;

    repeat (3) @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
